enc_bank: RTL and testbench

- Parametrised multi-channel quadrature rotary-encoder interface; successor to the single-channel, fixed-maximum Pmod encoder counter.
- Each channel synchronises and glitch-filters its A/B/switch pins, then decodes detents into a bounded position counter.
- Per-channel maximum, wrap/saturate mode, synchronous clear and change strobes are added.
- Sits between the Pmod headers and the memory controller / seven-segment display paths. It supplies x/y pixel position and colour.

---
 rtl/enc_pkg.sv | 19 +
 rtl/enc_channel.sv | 127 ++++++++++++
 rtl/enc_bank.sv | 44 ++++
 tb/tb_enc_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants and elaboration-time helpers for the encoder bank.
package enc_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

    // Extracts channel idx's w-bit maximum from the packed per-channel vector.
    function automatic int max_slice(input logic [127:0] vals, input int idx, input int w);
        return int'((vals >> (idx * w)) & ((128'd1 << w) - 128'd1));
    endfunction

endpackage

// File: rtl/enc_channel.sv
// One encoder channel: 2-flop sync and debounce on A/B/SW, detent decode, bounded position.
// Latency pin->pos is 2 + FILT_CYC + 1 cycles; no backpressure, pins are sampled every cycle.
module enc_channel
    import enc_pkg::*;
#(
    parameter int POS_W    = 8,
    parameter int MAX      = 255,
    parameter bit WRAP     = 1'b0,
    parameter int FILT_CYC = 5000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_sw,
    input  logic             i_clr,
    output logic [POS_W-1:0] o_pos,
    output logic             o_changed,
    output logic             o_dir,
    output logic             o_sw_level
);

    localparam int               CNT_W    = clog2(FILT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);
    localparam logic [POS_W-1:0] MAX_P    = POS_W'(MAX);

    logic [2:0]       w_pin;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       w_filt;
    logic             r_a_dly;
    logic             r_sw_dly;
    logic             w_step;
    logic             w_sw_evt;
    logic             w_dir_step;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_changed;

    assign w_pin = {i_sw, i_b, i_a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pin;
            r_sync2 <= r_sync1;
        end
    end

    // Index 0 = A, 1 = B, 2 = SW; each level only moves after FILT_CYC steady mismatch cycles.
    for (genvar g = 0; g < 3; g++) begin : g_filt
        logic [CNT_W-1:0] r_cnt;
        logic             r_lvl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (r_sync2[g] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_lvl <= r_sync2[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_filt[g] = r_lvl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_dly  <= 1'b0;
            r_sw_dly <= 1'b0;
        end else begin
            r_a_dly  <= w_filt[0];
            r_sw_dly <= w_filt[2];
        end
    end

    assign w_step     = w_filt[0] & ~r_a_dly;
    assign w_sw_evt   = w_filt[2] & ~r_sw_dly;
    assign w_dir_step = w_filt[1] ? DIR_DN : DIR_UP;

    // Increment only happens below MAX, so POS_W-bit arithmetic cannot carry out.
    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        if (i_clr || w_sw_evt) begin
            w_pos_nxt = '0;
        end else if (w_step) begin
            w_dir_nxt = w_dir_step;
            if (r_pos > MAX_P) begin
                w_pos_nxt = MAX_P;
            end else if (w_dir_step == DIR_UP) begin
                if (r_pos == MAX_P) w_pos_nxt = WRAP ? '0 : MAX_P;
                else                w_pos_nxt = r_pos + 1'b1;
            end else begin
                if (r_pos == '0) w_pos_nxt = WRAP ? MAX_P : '0;
                else             w_pos_nxt = r_pos - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos     <= '0;
            r_dir     <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_pos     <= w_pos_nxt;
            r_dir     <= w_dir_nxt;
            r_changed <= (w_pos_nxt != r_pos);
        end
    end

    assign o_pos      = r_pos;
    assign o_dir      = r_dir;
    assign o_changed  = r_changed;
    assign o_sw_level = w_filt[2];

endmodule

// File: rtl/enc_bank.sv
// Bank of NUM_CH independent quadrature encoder channels with per-channel max and wrap mode.
// Latency pin->pos is 2 + FILT_CYC + 1 cycles; no backpressure, outputs are free-running.
module enc_bank
    import enc_pkg::*;
#(
    parameter int                       NUM_CH    = 3,
    parameter int                       POS_W     = 8,
    parameter logic [NUM_CH*POS_W-1:0]  MAX_VALS  = {8'd255, 8'd119, 8'd159},
    parameter logic [NUM_CH-1:0]        WRAP_MASK = 3'b000,
    parameter int                       FILT_CYC  = 5000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         enc_a,
    input  logic [NUM_CH-1:0]         enc_b,
    input  logic [NUM_CH-1:0]         enc_sw,
    input  logic [NUM_CH-1:0]         clr,
    output logic [NUM_CH*POS_W-1:0]   pos,
    output logic [NUM_CH-1:0]         changed,
    output logic [NUM_CH-1:0]         dir,
    output logic [NUM_CH-1:0]         sw_level
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        enc_channel #(
            .POS_W    (POS_W),
            .MAX      (max_slice(128'(MAX_VALS), g, POS_W)),
            .WRAP     (WRAP_MASK[g]),
            .FILT_CYC (FILT_CYC)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_a        (enc_a[g]),
            .i_b        (enc_b[g]),
            .i_sw       (enc_sw[g]),
            .i_clr      (clr[g]),
            .o_pos      (pos[g*POS_W +: POS_W]),
            .o_changed  (changed[g]),
            .o_dir      (dir[g]),
            .o_sw_level (sw_level[g])
        );
    end

endmodule

// File: tb/tb_enc_bank.sv
// Bench for enc_bank with short filter: detent tables, corner sequences and random steps vs a model.
module tb_enc_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  enc_a, enc_b, enc_sw, clr;
    logic [23:0] pos;
    logic [2:0]  changed, dir, sw_level;

    enc_bank #(
        .NUM_CH    (3),
        .POS_W     (8),
        .MAX_VALS  ({8'd255, 8'd119, 8'd159}),
        .WRAP_MASK (3'b100),
        .FILT_CYC  (4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
        .clr(clr), .pos(pos), .changed(changed), .dir(dir), .sw_level(sw_level)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int maxv[3]  = '{159, 119, 255};
    bit wrapv[3] = '{1'b0, 1'b0, 1'b1};
    int m_pos[3] = '{0, 0, 0};
    int m_dir[3] = '{0, 0, 0};
    int m_chg[3] = '{0, 0, 0};
    int seen_chg[3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (changed[i]) seen_chg[i]++;
    end

    typedef struct {
        logic [2:0] mask;
        logic [2:0] up;
        int         n;
        int         ch;
        int         exp_pos;
        int         exp_dir;
    } row_t;

    row_t tbl[7];

    task automatic chk(input string name, input int ch, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s ch%0d: got %0d expected %0d", name, ch, got, exp);
        end
    endtask

    function automatic int next_pos(input int p, input int m, input bit wrap, input bit up);
        if (up) return (p == m) ? (wrap ? 0 : m) : p + 1;
        return (p == 0) ? (wrap ? m : 0) : p - 1;
    endfunction

    task automatic check_all(input string tag);
        for (int c = 0; c < 3; c++) begin
            chk({tag, "_pos"}, c, int'(pos[c*8 +: 8]), m_pos[c]);
            chk({tag, "_dir"}, c, int'(dir[c]), m_dir[c]);
            chk({tag, "_chgcnt"}, c, seen_chg[c], m_chg[c]);
        end
    endtask

    // One detent on every channel in mask simultaneously; also checks the 7-cycle latency.
    task automatic do_step(input logic [2:0] mask, input logic [2:0] up);
        int old_p[3];
        @(negedge clk);
        for (int c = 0; c < 3; c++) if (mask[c]) enc_b[c] = ~up[c];
        repeat (8) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            old_p[c] = m_pos[c];
            if (mask[c]) begin
                m_pos[c] = next_pos(m_pos[c], maxv[c], wrapv[c], up[c]);
                m_dir[c] = int'(up[c]);
                if (m_pos[c] != old_p[c]) m_chg[c]++;
            end
        end
        enc_a = enc_a | mask;
        repeat (6) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) if (mask[c]) chk("pre_latency_pos", c, int'(pos[c*8 +: 8]), old_p[c]);
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) if (mask[c]) begin
            chk("at_latency_pos", c, int'(pos[c*8 +: 8]), m_pos[c]);
            chk("at_latency_changed", c, int'(changed[c]), int'(m_pos[c] != old_p[c]));
        end
        @(negedge clk);
        enc_a = enc_a & ~mask;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{3'b001, 3'b001, 10,  0, 10,  1};
        tbl[1] = '{3'b010, 3'b000, 3,   1, 0,   0};
        tbl[2] = '{3'b010, 3'b010, 125, 1, 119, 1};
        tbl[3] = '{3'b100, 3'b000, 1,   2, 255, 0};
        tbl[4] = '{3'b100, 3'b100, 1,   2, 0,   1};
        tbl[5] = '{3'b100, 3'b000, 1,   2, 255, 0};
        tbl[6] = '{3'b010, 3'b000, 69,  1, 50,  0};

        rst_n = 1'b0; enc_a = '0; enc_b = '0; enc_sw = '0; clr = '0;
        repeat (3) @(negedge clk);
        chk("reset_pos", 0, int'(pos), 0);
        chk("reset_changed", 0, int'(changed), 0);
        chk("reset_dir", 0, int'(dir), 0);
        chk("reset_sw_level", 0, int'(sw_level), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < tbl[r].n; k++) do_step(tbl[r].mask, tbl[r].up);
            chk("table_pos", tbl[r].ch, int'(pos[tbl[r].ch*8 +: 8]), tbl[r].exp_pos);
            chk("table_dir", tbl[r].ch, int'(dir[tbl[r].ch]), tbl[r].exp_dir);
            check_all("table");
        end

        // 3-cycle A glitch on ch0 must be swallowed by the filter.
        @(negedge clk); enc_a[0] = 1'b1;
        repeat (3) @(negedge clk); enc_a[0] = 1'b0;
        repeat (12) @(negedge clk);
        check_all("glitch");

        // clr coincident with a step on ch0: clear wins.
        enc_b[0] = 1'b0;
        repeat (8) @(negedge clk);
        enc_a[0] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk); clr[0] = 1'b1;
        @(posedge clk); #1;
        chk("clr_vs_step_pos", 0, int'(pos[7:0]), 0);
        chk("clr_vs_step_changed", 0, int'(changed[0]), 1);
        m_pos[0] = 0; m_chg[0]++;
        @(negedge clk); clr[0] = 1'b0; enc_a[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("clr_vs_step_hold", 0, int'(pos[7:0]), 0);

        // 6-cycle switch press on ch1 at pos 50.
        @(negedge clk); enc_sw[1] = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("sw_level_early", 1, int'(sw_level[1]), 0);
        @(posedge clk); #1;
        chk("sw_level_rise", 1, int'(sw_level[1]), 1);
        chk("sw_pre_pos", 1, int'(pos[15:8]), 50);
        @(negedge clk); enc_sw[1] = 1'b0;
        @(posedge clk); #1;
        chk("sw_clear_pos", 1, int'(pos[15:8]), 0);
        chk("sw_clear_changed", 1, int'(changed[1]), 1);
        m_pos[1] = 0; m_chg[1]++;
        repeat (4) @(posedge clk); #1;
        chk("sw_level_hold", 1, int'(sw_level[1]), 1);
        @(posedge clk); #1;
        chk("sw_level_fall", 1, int'(sw_level[1]), 0);
        repeat (4) @(negedge clk);
        check_all("switch");

        for (int it = 0; it < 40; it++) begin
            do_step(3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)));
            check_all("random");
        end

        // Clear all, then bring ch0 to 7 for the asynchronous reset case.
        @(negedge clk); clr = 3'b111;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            chk("clr_all_pos", c, int'(pos[c*8 +: 8]), 0);
            chk("clr_all_changed", c, int'(changed[c]), int'(m_pos[c] != 0));
            if (m_pos[c] != 0) m_chg[c]++;
            m_pos[c] = 0;
        end
        @(negedge clk); clr = '0;
        for (int k = 0; k < 7; k++) do_step(3'b001, 3'b001);
        check_all("pre_reset");

        @(negedge clk); enc_a[0] = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_pos", 0, int'(pos[7:0]), 0);
        chk("async_reset_dir", 0, int'(dir[0]), 0);
        for (int c = 0; c < 3; c++) begin m_pos[c] = 0; m_dir[c] = 0; end
        enc_a = '0; enc_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_all("post_reset_idle");

        // A held high through reset release yields exactly one up step.
        rst_n = 1'b0; enc_a[0] = 1'b1; enc_b[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        m_pos[0] = 1; m_dir[0] = 1; m_chg[0]++;
        check_all("held_high");
        enc_a[0] = 1'b0;
        repeat (10) @(negedge clk);
        check_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
